// File: rtl/ttt_pkg.sv
// Shared constants, FSM state type and the winning-line table for the
// Tic-Tac-Toe move controller.
package ttt_pkg;

  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;

  localparam logic SYM_X = 1'b0;
  localparam logic SYM_O = 1'b1;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef logic [3:0] cell_idx_t;

  // Cell triples for the three rows, three columns and two diagonals.
  localparam cell_idx_t LINE_TBL [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: scans every line of the board and reports
// whether any is fully occupied by a single symbol.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [N_CELLS-1:0] valid,
  input  logic [N_CELLS-1:0] symbol,
  output logic               win,
  output logic               win_symbol
);

  // Walk the line table; lower-numbered lines take priority, although a
  // legal game can only ever complete lines of the player who just moved.
  always_comb begin
    win        = 1'b0;
    win_symbol = SYM_X;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (valid[LINE_TBL[i][0]] && valid[LINE_TBL[i][1]] && valid[LINE_TBL[i][2]] &&
          (symbol[LINE_TBL[i][0]] == symbol[LINE_TBL[i][1]]) &&
          (symbol[LINE_TBL[i][1]] == symbol[LINE_TBL[i][2]])) begin
        win        = 1'b1;
        win_symbol = (symbol[LINE_TBL[i][0]] == SYM_O) ? SYM_O : SYM_X;
      end
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-Tac-Toe move controller: accepts moves over valid/ready, rejects
// illegal ones, writes legal ones into the external cell array, then reads
// the board back to decide win/draw. Outputs come only from registers or
// the state register, so nothing combinational leaks from the inputs.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_SYMBOL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_pos,
  output logic               move_ready,
  input  logic [N_CELLS-1:0] cell_valid,
  input  logic [N_CELLS-1:0] cell_symbol,
  output logic [N_CELLS-1:0] cell_set,
  output logic               cell_set_symbol,
  output logic               cell_reset,
  output logic               turn,
  output logic               move_err,
  output logic [3:0]         move_count,
  output logic               game_over,
  output logic               winner_valid,
  output logic               winner,
  output logic               draw
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  pos_q;
  logic [15:0] occ_ext;
  logic        illegal;
  logic        accept;
  logic        win;
  logic        win_symbol;

  // Zero-extend occupancy so out-of-range positions index a defined bit.
  assign occ_ext = {7'd0, cell_valid};
  assign illegal = (move_pos > 4'd8) || occ_ext[move_pos];

  // new_game swallows any simultaneous request, so it never counts as accepted.
  assign move_ready = (state == IDLE) || (state == OVER);
  assign accept     = move_valid && move_ready && !new_game;

  // Cell-array controls are decoded from state plus the latched position.
  assign cell_reset      = (state == CLEAR);
  assign cell_set        = (state == WRITE) ? (N_CELLS'(1) << pos_q) : '0;
  assign cell_set_symbol = (state == WRITE) ? turn : 1'b0;

  ttt_line_check u_line_check (
    .valid      (cell_valid),
    .symbol     (cell_symbol),
    .win        (win),
    .win_symbol (win_symbol)
  );

  // Next-state logic; new_game overrides whatever the current state wants.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   state_nxt = IDLE;
      IDLE:    if (accept && !illegal) state_nxt = WRITE;
      WRITE:   state_nxt = CHECK;
      CHECK:   state_nxt = (win || (move_count == 4'd9)) ? OVER : IDLE;
      OVER:    state_nxt = OVER;
      default: state_nxt = CLEAR;
    endcase
    if (new_game) state_nxt = CLEAR;
  end

  // State register; reset parks the FSM in CLEAR so the board is wiped.
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Game bookkeeping: position latch, turn, move count, result flags.
  // Clearing on the new_game edge makes the cleared values visible already
  // during the CLEAR cycle.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      pos_q        <= 4'd0;
      turn         <= FIRST_SYMBOL;
      move_count   <= 4'd0;
      move_err     <= 1'b0;
      game_over    <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      draw         <= 1'b0;
    end else begin
      move_err <= accept && ((state == OVER) || ((state == IDLE) && illegal));
      case (state)
        CLEAR: begin
          turn         <= FIRST_SYMBOL;
          move_count   <= 4'd0;
          game_over    <= 1'b0;
          winner_valid <= 1'b0;
          winner       <= 1'b0;
          draw         <= 1'b0;
        end
        IDLE: begin
          if (accept && !illegal) pos_q <= move_pos;
        end
        WRITE: begin
          move_count <= move_count + 4'd1;
        end
        CHECK: begin
          if (win) begin
            winner_valid <= 1'b1;
            winner       <= win_symbol;
            game_over    <= 1'b1;
          end else if (move_count == 4'd9) begin
            draw      <= 1'b1;
            game_over <= 1'b1;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ttt_move_ctrl.md
# ttt_move_ctrl

Game controller that sits directly upstream of the nine-cell Tic-Tac-Toe board array. It accepts move requests over a valid/ready handshake and checks each move for legality. For a legal move it writes the cell through the per-cell set, set-symbol and reset controls, alternates turns, and detects win or draw by reading back the cells' valid and symbol outputs. Symbol 0 = X, symbol 1 = O.

## Interface
Parameters:
- FIRST_SYMBOL, default 1'b0: symbol that moves first after reset or new game.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- new_game  in  1  pulse; abandons the current game and clears the board
- move_valid  in  1  move request present
- move_pos  in  4  cell index 0..8, row-major (0 = top-left)
- move_ready  out  1  controller can accept a move this cycle
- cell_valid  in  9  occupancy bits from the cell array, bit i = cell i
- cell_symbol  in  9  symbol bits from the cell array
- cell_set  out  9  one-hot write strobe to the cells
- cell_set_symbol  out  1  symbol written with cell_set
- cell_reset  out  1  clears all cells
- turn  out  1  symbol of the player to move
- move_err  out  1  one-cycle pulse; rejected move
- move_count  out  4  moves applied in the current game, 0..9
- game_over  out  1  game finished
- winner_valid  out  1  game ended in a win
- winner  out  1  winning symbol; meaningful only when winner_valid=1
- draw  out  1  game ended with a full board and no win

## Operation
- FSM states:
  - CLEAR: cell_reset=1, move_ready=0; clears move_count, turn, game_over, winner_valid, winner and draw; next state IDLE.
  - IDLE: move_ready=1. A handshake (move_valid && move_ready) is accepted.
  - WRITE: cell_set[pos]=1, cell_set_symbol=turn, move_count+1; next state CHECK.
  - CHECK: evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on cell_valid/cell_symbol.
    - A line is won when all three cells are valid and their symbols are equal. On a win: winner_valid=1, winner=that symbol, game_over=1, next state OVER.
    - If there is no win and move_count==9: draw=1, game_over=1, next state OVER.
    - Otherwise turn toggles and the next state is IDLE.
  - OVER: move_ready=1. Every accepted move is rejected with move_err. Only new_game or reset leaves OVER.
- Legality is checked in IDLE in the acceptance cycle. A move is illegal if move_pos>8 or cell_valid[move_pos]=1.
  - Illegal move: move_err pulses the next cycle; the FSM stays in IDLE; turn, count and cells are unchanged.
- new_game in any state: next state CLEAR.
  - It has priority over a simultaneous handshake; that move is dropped with no move_err.
- reset forces state CLEAR, so the cells are cleared in the first cycle after reset deasserts.
- Reset values: move_ready=0, cell_set=0, cell_set_symbol=0, cell_reset=1, turn=FIRST_SYMBOL, move_count=0, move_err=0, game_over=0, winner_valid=0, winner=0, draw=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from move_valid, move_pos or cell_* to any output.

## Timing
- A move is accepted at cycle T.
  - T+1: WRITE (cell_set high for exactly one cycle); the cell latches at the end of T+1.
  - T+2: CHECK sees the updated cell_valid/cell_symbol.
  - T+3: IDLE (move_ready=1, turn toggled) or OVER (game_over, winner or draw set).
- move_ready is low in T+1 and T+2. Legal-move throughput is 1 move per 3 cycles.
- An illegal move gets move_err at T+1. move_ready stays high, so back-to-back requests are allowed.
- new_game at cycle T: CLEAR at T+1 (cell_reset high for one cycle), IDLE at T+2.
- game_over, winner_valid, winner and draw hold until the next CLEAR.

## Structure
- ttt_pkg holds:
  - N_CELLS=9;
  - SYM_X=1'b0, SYM_O=1'b1;
  - the state enum {CLEAR, IDLE, WRITE, CHECK, OVER};
  - an 8-entry constant table of line cell-index triples.
- Sub-module ttt_line_check is purely combinational.
  - Inputs: valid[8:0], symbol[8:0].
  - Outputs: win, win_symbol.
  - It iterates over the package line table.

## Test plan
- Reset, then moves 0,3,1,4,2: cell_set one-hot per move with symbols alternating 0/1. After the 5th CHECK: winner_valid=1, winner=0, game_over=1, move_count=5.
- Move 4 (X), then move 4 (O): the second move gets move_err at T+1, no cell_set asserts, turn stays 1, move_count stays 1.
- move_pos=9 and move_pos=15 in IDLE: move_err each time, state unchanged, move_ready stays 1.
- Moves 0,1,2,4,3,5,7,6,8: draw=1, winner_valid=0, game_over=1, move_count=9.
- After 3 legal moves, assert new_game in the same cycle as move_valid (pos 8): no move_err, no cell_set; cell_reset high for one cycle; then turn=FIRST_SYMBOL, move_count=0, move_ready=1.
- Move requested while game_over=1: move_err pulses, cell_set stays 0, winner/draw unchanged. A following new_game returns to IDLE.
